serial_parity_tx: RTL and testbench

- Upstream stage of the serial parity checker.
- Accepts parallel words over a valid/ready handshake and shifts each word out LSB-first on a single-bit serial line `x`.
- Appends one computed parity bit to each word, giving a frame of DATA_W+1 bits that the downstream Mealy parity checker consumes bit by bit.
- Drives frame-delimiting strobes so the checker (and its bench) can align frames.

---
 rtl/serial_parity_tx_pkg.sv | 21 ++
 rtl/serial_parity_tx.sv | 109 ++++++++++
 tb/tb_serial_parity_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_tx_pkg.sv
// Shared constants for the serial parity transmitter and its downstream checker:
// FSM state encoding, parity-mode selectors and the parity-bit helper.
package serial_parity_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Turns the XOR of the data bits into the transmitted parity bit for a given mode.
  function automatic logic parity_bit(input logic acc, input int mode);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      default:  return acc;
    endcase
  endfunction

endpackage

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter: shifts each accepted word out LSB-first on x,
// then appends one parity bit. Frames can run back-to-back with no gap cycle.
module serial_parity_tx
  import serial_parity_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              x_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]        state, state_next;
  logic [DATA_W-1:0] sreg, sreg_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              acc, acc_next;
  logic              x_next, x_valid_next, frame_start_next, frame_end_next, busy_next;
  logic              accept;

  // The parity cycle also accepts, which is what lets frames abut without a gap.
  assign din_ready = (state == ST_IDLE) || (state == ST_PARITY);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_next       = state;
    sreg_next        = sreg;
    cnt_next         = cnt;
    acc_next         = acc;
    x_next           = 1'b0;
    x_valid_next     = 1'b0;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
          sreg_next  = din;
          cnt_next   = '0;
          acc_next   = ^din;
        end
      end
      ST_SHIFT: begin
        x_next           = sreg[0];
        x_valid_next     = 1'b1;
        frame_start_next = (cnt == '0);
        sreg_next        = sreg >> 1;
        cnt_next         = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        x_next         = parity_bit(acc, PARITY_ODD);
        x_valid_next   = 1'b1;
        frame_end_next = 1'b1;
        if (accept) begin
          state_next = ST_SHIFT;
          sreg_next  = din;
          cnt_next   = '0;
          acc_next   = ^din;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      acc         <= 1'b0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      sreg        <= sreg_next;
      cnt         <= cnt_next;
      acc         <= acc_next;
      x           <= x_next;
      x_valid     <= x_valid_next;
      frame_start <= frame_start_next;
      frame_end   <= frame_end_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench for serial_parity_tx: an even-parity and an odd-parity instance
// share one stimulus stream; every expected frame bit is queued with its due cycle.
module tb_serial_parity_tx;

  typedef struct {
    logic x;
    logic fs;
    logic fe;
    int   cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       ready [2];
  logic       xo    [2];
  logic       xv    [2];
  logic       fs    [2];
  logic       fe    [2];
  logic       bsy   [2];

  exp_t q [2][$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   run_len;
  int   last_run;

  serial_parity_tx #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready[0]),
    .x(xo[0]), .x_valid(xv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bsy[0])
  );

  serial_parity_tx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready[1]),
    .x(xo[1]), .x_valid(xv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Due bits are popped in cycle order; anything valid with nothing due is an error.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        if (q[d].size() > 0 && q[d][0].cyc <= cyc) begin
          exp_t e;
          e = q[d].pop_front();
          check_output($sformatf("dut%0d x_valid", d), 32'(xv[d]), 32'd1);
          check_output($sformatf("dut%0d x", d), 32'(xo[d]), 32'(e.x));
          check_output($sformatf("dut%0d frame_start", d), 32'(fs[d]), 32'(e.fs));
          check_output($sformatf("dut%0d frame_end", d), 32'(fe[d]), 32'(e.fe));
        end else if (xv[d]) begin
          check_output($sformatf("dut%0d unexpected x_valid", d), 32'(xv[d]), 32'd0);
        end
      end
      if (xv[0]) begin
        run_len++;
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] w, input bit hold);
    int   guard;
    int   n;
    exp_t e;
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    guard     = 0;
    while (!ready[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_output("din_ready timeout", 32'(ready[0]), 32'd1);
    n = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        e.x = w[k]; e.fs = (k == 0); e.fe = 1'b0; e.cyc = n + 1 + k;
        q[d].push_back(e);
      end
      e.x = (d == 0) ? ^w : ~^w; e.fs = 1'b0; e.fe = 1'b1; e.cyc = n + 9;
      q[d].push_back(e);
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while ((q[0].size() > 0 || q[1].size() > 0 || xv[0] || xv[1]) && guard < 100);
    if (guard >= 100) check_output({tag, " idle timeout"}, 32'd0, 32'd1);
    check_output({tag, " busy after frame"}, 32'(bsy[0]), 32'd0);
    check_output({tag, " din_ready after frame"}, 32'(ready[0]), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("%s dut%0d x", tag, d), 32'(xo[d]), 32'd0);
      check_output($sformatf("%s dut%0d x_valid", tag, d), 32'(xv[d]), 32'd0);
      check_output($sformatf("%s dut%0d frame_start", tag, d), 32'(fs[d]), 32'd0);
      check_output($sformatf("%s dut%0d frame_end", tag, d), 32'(fe[d]), 32'd0);
      check_output($sformatf("%s dut%0d busy", tag, d), 32'(bsy[d]), 32'd0);
      check_output($sformatf("%s dut%0d din_ready", tag, d), 32'(ready[d]), 32'd1);
    end
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_err     = 0;
    run_len   = 0;
    last_run  = 0;
    reset     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    check_reset_values("power-on reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    $display("[TB] single frame 8'hA5");
    apply_stimulus(8'hA5, 1'b0);
    wait_idle("A5");
    check_output("A5 x_valid run length", 32'(last_run), 32'd9);

    $display("[TB] single frame 8'h07");
    apply_stimulus(8'h07, 1'b0);
    wait_idle("07");

    $display("[TB] single frame 8'h00");
    apply_stimulus(8'h00, 1'b0);
    wait_idle("00");

    $display("[TB] back-to-back 8'hFF then 8'h01");
    apply_stimulus(8'hFF, 1'b1);
    apply_stimulus(8'h01, 1'b0);
    wait_idle("b2b");
    check_output("b2b x_valid run length", 32'(last_run), 32'd18);

    $display("[TB] stall during shift");
    apply_stimulus(8'hC3, 1'b0);
    @(negedge clk);
    din       = 8'h3C;
    din_valid = 1'b1;
    #1;
    check_output("stall din_ready", 32'(ready[0]), 32'd0);
    check_output("stall busy", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
    din       = 8'hFF;
    wait_idle("stall");
    apply_stimulus(8'h3C, 1'b0);
    wait_idle("3C");

    $display("[TB] reset mid-frame");
    apply_stimulus(8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    check_reset_values("mid-frame reset");
    run_len = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    apply_stimulus(8'h07, 1'b0);
    wait_idle("post-reset 07");
    check_output("post-reset x_valid run length", 32'(last_run), 32'd9);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
